// File: rtl/cva6_cheri_tag_store.sv
// rtl/cva6_cheri_tag_store.sv - CHERI tag memory with row access, write mask and sweep clear
//
// Stores one tag bit per CAP_BYTES capability slot of [BASE_ADDR, BASE_ADDR+MEM_BYTES).
// Each access reads (and optionally masked-writes) one row of TAGS_PER_ROW tags.
// Rows are cleared by a one-row-per-cycle sweep after reset and on flush.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   flush_i                request a full tag clear (sampled in READY)
//   req_valid_i/ready_o    request handshake; req_we_i, req_addr_i, req_wmask_i, req_wdata_i
//   rsp_valid_o/ready_i    response handshake; rsp_rdata_o (old row contents), rsp_err_o
//   init_done_o            high once the clear sweep has finished
module cva6_cheri_tag_store #(
  parameter int unsigned              ADDR_WIDTH   = 64,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR    = ADDR_WIDTH'(64'h8000_0000),
  parameter int unsigned              MEM_BYTES    = 2**25,
  parameter int unsigned              CAP_BYTES    = 16,
  parameter int unsigned              TAGS_PER_ROW = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [TAGS_PER_ROW-1:0] req_wmask_i,
  input  logic [TAGS_PER_ROW-1:0] req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [TAGS_PER_ROW-1:0] rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    init_done_o
);

  localparam int unsigned ROW_BYTES = CAP_BYTES * TAGS_PER_ROW;
  localparam int unsigned DEPTH     = MEM_BYTES / ROW_BYTES;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OFF_SH    = $clog2(ROW_BYTES);

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES_W = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [IDX_W-1:0]      LAST_ROW    = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [TAGS_PER_ROW-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   off;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    accept;
  logic [TAGS_PER_ROW-1:0] row_old;

  // The offset wraps for addresses below BASE_ADDR, so the lower-bound test is explicit.
  assign off      = req_addr_i - BASE_ADDR;
  assign in_range = (req_addr_i >= BASE_ADDR) && (off < MEM_BYTES_W);
  assign idx      = off[OFF_SH +: IDX_W];
  assign row_old  = mem[idx];

  assign init_done_o = (state_q == S_READY);
  // Ready never looks at req_valid_i, so the handshake cannot form a combinational loop.
  assign req_ready_o = (state_q == S_READY) && !flush_i && (!rsp_valid_o || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == LAST_ROW) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      S_READY: begin
        if (flush_i) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= in_range ? row_old : '0;
        rsp_err_o   <= !in_range;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

  // Storage has no reset; the sweep clears it. Writing at the accepting edge makes a
  // following request see the new value without a bypass path.
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      mem[cnt_q] <= '0;
    end else if (accept && in_range && req_we_i) begin
      mem[idx] <= (row_old & ~req_wmask_i) | (req_wdata_i & req_wmask_i);
    end
  end

endmodule

// File: doc/cva6_cheri_tag_store.md
Name:
cva6_cheri_tag_store

Overview:
- Parametrised next-generation CHERI tag memory for the CVA6 testbench: one tag bit per CAP_BYTES-sized capability slot in a memory region starting at BASE_ADDR.
- Each access covers one row of TAGS_PER_ROW tags, with a per-tag write mask.
- Requests use a valid/ready handshake; responses have 1-cycle latency with backpressure and an out-of-range error flag.
- Tags are cleared by a sequential sweep after reset and on a flush request, so no single-cycle wide reset is needed.

Parameters:
- ADDR_WIDTH, 64: request byte-address width.
- BASE_ADDR, 64'h8000_0000: first byte covered by the tag store.
- MEM_BYTES, 2**25: bytes covered; power of two.
- CAP_BYTES, 16: bytes per capability, i.e. per tag; power of two.
- TAGS_PER_ROW, 4: tags per row/access; power of two, ≥1.
- Derived: ROW_BYTES = CAP_BYTES*TAGS_PER_ROW; DEPTH = MEM_BYTES/ROW_BYTES rows; IDX_W = max(1, clog2(DEPTH)).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  request a full tag clear (level, sampled in READY).
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address; bits below log2(ROW_BYTES) ignored.
- req_wmask_i  in  TAGS_PER_ROW  bit i enables a write of tag i (capability at row_base + i*CAP_BYTES).
- req_wdata_i  in  TAGS_PER_ROW  tag values to write.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&&ready.
- rsp_rdata_o  out  TAGS_PER_ROW  read tags; pre-write contents for writes.
- rsp_err_o  out  1  address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES).
- init_done_o  out  1  high in READY.

Behaviour:
- Reset (async assert): state=INIT, sweep counter=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, init_done_o=0, req_ready_o=0. Reset mid-sweep or mid-response aborts and restarts the sweep at row 0; a pending response is dropped.
- FSM states: INIT, READY.
- INIT: each cycle, row[cnt] <= 0 and cnt++. After row DEPTH-1 is written, go to READY; cnt wraps to 0. The sweep takes exactly DEPTH cycles. req_ready_o=0 throughout.
- READY: init_done_o=1. req_ready_o = !flush_i && (!rsp_valid_o || rsp_ready_i). This is combinational from flush_i/rsp_ready_i only, never from req_valid_i.
- Flush: if flush_i=1 in READY, go to INIT next edge with cnt=0. No request is accepted in that cycle. A pending response stays valid and must still be consumed.
- Accepted request: off = addr - BASE_ADDR, computed at ADDR_WIDTH with unsigned wrap. In range iff addr >= BASE_ADDR && off < MEM_BYTES; idx = off >> log2(ROW_BYTES).
- In range: rsp_rdata_o <= row[idx] (old value); err=0. For a write, for each i with wmask[i]=1, row[idx][i] <= wdata[i]; unmasked tags are unchanged.
- Out of range: no storage change; rsp_rdata_o <= 0; err=1.
- Latency: request accepted at edge N; rsp_valid_o=1 after edge N. It falls after the edge where rsp_ready_i=1, unless a new request is accepted on that same edge, in which case it stays 1 with new data (back-to-back, 1 request/cycle).
- While rsp_valid_o=1 && rsp_ready_i=0, rsp_rdata_o and rsp_err_o hold stable.
- Read-after-write: a request accepted the cycle after a write sees the written value. No bypass is needed because storage is updated at the accepting edge.

Test Plan:
(MEM_BYTES=1024, TAGS_PER_ROW=4, CAP_BYTES=16 → DEPTH=16, BASE=0x8000_0000)
- Release rst_i → init_done_o and req_ready_o low for exactly 16 cycles, then high. A read of 0x8000_03C0 returns rdata=4'b0000, err=0.
- Write 0x8000_0010 with wmask=4'b0110, wdata=4'b1111 → response rdata=0000. A back-to-back read of 0x8000_0000 → rdata=4'b0110. Write mask 4'b0010, wdata 0 → next read 4'b0100.
- Write 0x8000_0400, then read 0x7FFF_FFF0 → both responses err=1, rdata=0. Row 15 and row 0 contents are unchanged.
- Hold rsp_ready_i=0 for 3 cycles with req_valid_i=1 → rsp_valid_o stays 1 with stable data, req_ready_o=0. When rsp_ready_i=1 the next request is accepted the same cycle.
- Set tags in rows 0 and 15, then pulse flush_i with req_valid_i=1 → the request is not accepted, 16 sweep cycles follow, and both rows read 0000.
- Assert rst_i at sweep cycle 5, and again with a response pending → rsp_valid_o=0 immediately. After release the sweep restarts and takes the full 16 cycles.
